mem_arbiter: RTL and testbench

// Shares one single-port 16-bit memory among NUM_REQ requesters (host loader, systolic-array feeders, result writer).

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester-side and memory-side signals of mem_arbiter.
//
//   req       requester -> arbiter   per-requester request, bit i = requester i
//   write_in  requester -> arbiter   per-requester op (1 write, 0 read)
//   addr_in   requester -> arbiter   packed addresses, slice i = [i*ADDR_W +: ADDR_W]
//   wdata_in  requester -> arbiter   packed write data, sliced like addr_in
//   gnt       arbiter -> requester   one-hot combinational grant
//   rvalid    arbiter -> requester   one-hot, read data for requester i on rdata
//   rdata     arbiter -> requester   read data, straight from mem_dout
//   mem_en    arbiter -> memory      memory enable
//   mem_write arbiter -> memory      memory write strobe
//   mem_addr  arbiter -> memory      memory address
//   mem_din   arbiter -> memory      memory write data
//   mem_dout  memory  -> arbiter     registered memory read data
//
// slave  : the arbiter's view.
// master : the environment's view (requesters plus the memory itself).
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        write_in;
   logic [NUM_REQ*ADDR_W-1:0] addr_in;
   logic [NUM_REQ*DATA_W-1:0] wdata_in;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;
   logic                      mem_en;
   logic                      mem_write;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_din;
   logic [DATA_W-1:0]         mem_dout;

   modport slave (
      input  req, write_in, addr_in, wdata_in, mem_dout,
      output gnt, rvalid, rdata, mem_en, mem_write, mem_addr, mem_din
   );

   modport master (
      output req, write_in, addr_in, wdata_in, mem_dout,
      input  gnt, rvalid, rdata, mem_en, mem_write, mem_addr, mem_din
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory among NUM_REQ requesters. Grants rotate
// round-robin; an owner keeps the port for up to MAX_BURST consecutive beats
// while it holds its request. Read data coming back from the memory's
// registered output is tagged with a one-hot rvalid for the requester that
// issued the read one cycle earlier.
//
// Ports
//   clk_i   clock, all state changes on the rising edge
//   rst_i   synchronous active-high reset
//   bus     mem_arbiter_if.slave, requester handshake plus memory pins
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.slave  bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    owner_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [CNT_W-1:0]    beat_cnt_q;
   logic [NUM_REQ-1:0]  rvalid_q;

   // Per-requester views of the packed buses
   logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

   logic                keep;
   logic [IDX_W-1:0]    base_idx;
   logic [IDX_W-1:0]    gnt_idx;
   logic                beat;
   logic                read_beat;
   logic [NUM_REQ-1:0]  gnt_vec;

   function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
      if (int'(v) == NUM_REQ - 1)
         return '0;
      return v + 1'b1;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign addr_arr[gi]  = bus.addr_in[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = bus.wdata_in[gi*DATA_W +: DATA_W];
         assign gnt_vec[gi]   = beat && (gnt_idx == IDX_W'(gi));
      end
   endgenerate

   // Grant selection. The current owner keeps the port while it still
   // requests and has burst budget left; otherwise the search starts just
   // past the owner so that an exhausted owner only wins if nobody else asks.
   always_comb begin
      int s;
      keep     = (state_q == OWN) && bus.req[owner_q] && (beat_cnt_q < MAX_CNT);
      base_idx = (state_q == OWN) ? inc_wrap(owner_q) : rr_ptr_q;
      gnt_idx  = '0;
      beat     = 1'b0;
      // Scan from farthest to nearest so the nearest requester is the last
      // (winning) assignment.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         s = int'(base_idx) + k;
         if (s >= NUM_REQ)
            s = s - NUM_REQ;
         if (bus.req[s]) begin
            gnt_idx = IDX_W'(s);
            beat    = 1'b1;
         end
      end
      if (keep)
         gnt_idx = owner_q;
      if (rst_i)
         beat = 1'b0;
   end

   assign read_beat     = beat && !bus.write_in[gnt_idx];

   assign bus.gnt       = gnt_vec;
   assign bus.mem_en    = beat;
   assign bus.mem_write = beat && bus.write_in[gnt_idx];
   assign bus.mem_addr  = beat ? addr_arr[gnt_idx]  : '0;
   assign bus.mem_din   = beat ? wdata_arr[gnt_idx] : '0;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = bus.mem_dout;

   // Ownership FSM plus the read-return tag pipeline
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         rvalid_q   <= '0;
      end else begin
         // Memory output is registered, so the tag lags the beat by one cycle
         rvalid_q <= read_beat ? gnt_vec : '0;
         if (!beat) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
         end else if (keep) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
         end else begin
            // New owner, or the exhausted owner re-granted after rotation
            state_q    <= OWN;
            owner_q    <= gnt_idx;
            beat_cnt_q <= ONE_CNT;
            rr_ptr_q   <= inc_wrap(gnt_idx);
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   localparam int N  = 2;
   localparam int DW = 16;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req;
   logic [N-1:0]    wr;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic            mem_load;
   logic            sel;

   mem_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus0 ();
   mem_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus1 ();

   mem_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4)) u_dut0 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus0.slave)
   );

   mem_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(1)) u_dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus1.slave)
   );

   assign bus0.req = req;   assign bus0.write_in = wr;
   assign bus0.addr_in = addr;   assign bus0.wdata_in = wdata;
   assign bus1.req = req;   assign bus1.write_in = wr;
   assign bus1.addr_in = addr;   assign bus1.wdata_in = wdata;

   // Memories behind each arbiter: registered read, write on enable
   logic [DW-1:0] mem0 [0:255];
   logic [DW-1:0] mem1 [0:255];
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) begin
            mem0[i] <= DW'(i);
            mem1[i] <= DW'(i);
         end
      end else begin
         if (bus0.mem_en) begin
            if (bus0.mem_write) mem0[bus0.mem_addr] <= bus0.mem_din;
            else                bus0.mem_dout <= mem0[bus0.mem_addr];
         end
         if (bus1.mem_en) begin
            if (bus1.mem_write) mem1[bus1.mem_addr] <= bus1.mem_din;
            else                bus1.mem_dout <= mem1[bus1.mem_addr];
         end
      end
   end

   // Observed DUT selected by sel
   logic [N-1:0]  o_gnt, o_rvalid;
   logic [DW-1:0] o_rdata, o_din;
   logic [AW-1:0] o_addr;
   logic          o_en, o_wr;
   assign o_gnt    = sel ? bus1.gnt       : bus0.gnt;
   assign o_rvalid = sel ? bus1.rvalid    : bus0.rvalid;
   assign o_rdata  = sel ? bus1.rdata     : bus0.rdata;
   assign o_din    = sel ? bus1.mem_din   : bus0.mem_din;
   assign o_addr   = sel ? bus1.mem_addr  : bus0.mem_addr;
   assign o_en     = sel ? bus1.mem_en    : bus0.mem_en;
   assign o_wr     = sel ? bus1.mem_write : bus0.mem_write;

   typedef struct packed {
      logic [N-1:0]  rv;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb_q [$];
   logic [DW-1:0] ref_mem [0:255];
   int            tests = 0;
   int            fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One cycle: drive, check at negedge, push the expected read return
   task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [N-1:0] eg, input logic late_rst);
      exp_t          e;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew;
      req   = r;
      wr    = w;
      addr  = {a1, a0};
      wdata = {d1, d0};
      @(negedge clk);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else                 e = '0;
      chk({tag, ":rvalid"}, 32'(o_rvalid), 32'(e.rv));
      if (e.rv != '0)
         chk({tag, ":rdata"}, 32'(o_rdata), 32'(e.data));
      chk({tag, ":gnt"}, 32'(o_gnt), 32'(eg));
      chk({tag, ":mem_en"}, 32'(o_en), 32'(|eg));
      ea = eg[1] ? a1 : a0;
      ed = eg[1] ? d1 : d0;
      ew = eg[1] ? w[1] : w[0];
      if (eg != '0) begin
         chk({tag, ":mem_addr"}, 32'(o_addr), 32'(ea));
         chk({tag, ":mem_write"}, 32'(o_wr), 32'(ew));
         if (ew) chk({tag, ":mem_din"}, 32'(o_din), 32'(ed));
      end else begin
         chk({tag, ":mem_write"}, 32'(o_wr), 32'd0);
         if (rst) begin
            chk({tag, ":mem_addr"}, 32'(o_addr), 32'd0);
            chk({tag, ":mem_din"}, 32'(o_din), 32'd0);
         end
      end
      e = '0;
      if (eg != '0) begin
         if (ew) begin
            ref_mem[ea] = ed;
         end else if (!late_rst) begin
            e.rv   = eg;
            e.data = ref_mem[ea];
         end
      end
      sb_q.push_back(e);
      if (late_rst) rst = 1'b1;
      $display("[TB] %s rst=%0b req=%b gnt=%b rvalid=%b rdata=%h", tag, rst, r, o_gnt, o_rvalid, o_rdata);
      @(posedge clk);
      #1;
   endtask

   initial begin
      req = '0; wr = '0; addr = '0; wdata = '0;
      sel = 1'b0;
      mem_load = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i);
      @(posedge clk);
      #1;
      mem_load = 1'b0;

      // Reset held with both requesting
      step("rst_a", 2'b11, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);
      step("rst_b", 2'b11, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);
      rst = 1'b0;

      // Write then read back, owner drops, req1 takes over with reads
      step("wr_beef", 2'b11, 2'b01, 8'h10, 8'h02, 16'hBEEF, 16'h0, 2'b01, 1'b0);
      step("rd_beef", 2'b11, 2'b00, 8'h10, 8'h02, 16'h0, 16'h0, 2'b01, 1'b0);
      step("drop0_r1", 2'b10, 2'b00, 8'h00, 8'h02, 16'h0, 16'h0, 2'b10, 1'b0);
      step("r1_rd10", 2'b10, 2'b00, 8'h00, 8'h10, 16'h0, 16'h0, 2'b10, 1'b0);
      step("idle_a", 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);

      // Sustained contention with burst limit 4
      for (int k = 0; k < 16; k++) begin
         step($sformatf("burst_%0d", k), 2'b11, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0,
              ((k / 4) % 2 == 1) ? 2'b10 : 2'b01, 1'b0);
      end
      step("idle_b", 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);

      // Reset landing on a read beat; rr pointer must return to 0
      step("pre_rr", 2'b01, 2'b00, 8'h01, 8'h00, 16'h0, 16'h0, 2'b01, 1'b0);
      step("idle_c", 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);
      step("rd_rst", 2'b11, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b10, 1'b1);
      step("in_rst", 2'b11, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b00, 1'b0);
      rst = 1'b0;
      step("post_rst", 2'b11, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b01, 1'b0);
      step("idle_d", 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);

      // Burst limit 1: alternating reads on the second arbiter
      sel = 1'b1;
      rst = 1'b1;
      step("b1_rst", 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step($sformatf("alt_%0d", k), 2'b11, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0,
              (k % 2 == 1) ? 2'b10 : 2'b01, 1'b0);
      end
      step("b1_drain_a", 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);
      step("b1_drain_b", 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
